img_mem_reader: RTL

Streams a rectangular region of an 8-bit image held in `onchip_mem_img` out as a valid/ready pixel stream. It is the read-side client of the image RAM. It generates row-major read addresses for a base/width/height/stride window. It absorbs the RAM's 1-cycle registered read latency and downstream backpressure with a small prefetch FIFO, and marks row and frame boundaries for the downstream interpolation or DMA-out stage.

---
 rtl/img_mem_reader_pkg.sv | 23 ++
 rtl/img_mem_reader_if.sv | 12 +
 rtl/img_mem_reader_stream_fifo.sv | 54 +++++
 rtl/img_mem_reader.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/img_mem_reader_pkg.sv
// Shared types and constants for the image-RAM read streamer:
// FSM states, prefetch FIFO geometry and the FIFO entry layout.
package img_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    // Flags are computed when the read is issued and ride along with the data.
    typedef struct packed {
        logic [7:0] data;
        logic       sol;
        logic       eol;
        logic       last;
    } fifo_entry_t;

endpackage

// File: rtl/img_mem_reader_if.sv
// Valid/ready pixel stream carrying row/frame boundary markers.
interface img_stream_if;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_sol;
    logic       m_eol;
    logic       m_last;

    modport master (output m_valid, m_data, m_sol, m_eol, m_last, input m_ready);
    modport slave  (input m_valid, m_data, m_sol, m_eol, m_last, output m_ready);
endinterface

// File: rtl/img_mem_reader_stream_fifo.sv
// 4-entry synchronous prefetch FIFO; simultaneous push and pop are both honoured.
module stream_fifo
    import img_stream_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  fifo_entry_t        din,
    input  logic               pop,
    output fifo_entry_t        dout,
    output logic [CNT_W-1:0]   count,
    output logic               empty,
    output logic               full
);

    fifo_entry_t      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign count     = r_count;
    assign dout      = r_mem[r_rptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // NOTE: storage carries no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/img_mem_reader.sv
// Reads a base/width/height/stride window from the image RAM in row-major order
// and streams it out with start-of-row, end-of-row and last-pixel markers.
module img_mem_reader
    import img_stream_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DIM_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIM_W-1:0]  roi_w,
    input  logic [DIM_W-1:0]  roi_h,
    input  logic [ADDR_W-1:0] stride,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [7:0]        mem_rdata,
    img_stream_if.master      m_axis
);

    localparam int CRD_W = CNT_W + 1;

    state_t            r_state, w_state_nxt;
    logic [DIM_W-1:0]  r_w, r_h, r_col, r_row;
    logic [ADDR_W-1:0] r_stride, r_row_base, r_raddr;
    logic              r_p1_vld, r_p2_vld, r_done;
    logic [2:0]        r_p1_flg, r_p2_flg;

    logic              w_idle, w_zero, w_issue, w_done_nxt, w_pop, w_credit_ok;
    logic              w_col_end, w_row_end, w_last_px;
    logic [DIM_W-1:0]  w_cur_w, w_cur_h, w_cur_col, w_cur_row;
    logic [ADDR_W-1:0] w_cur_stride, w_cur_row_base;
    logic [CRD_W-1:0]  w_credit;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_empty, w_fifo_full;
    fifo_entry_t       w_fifo_din, w_head;

    // In IDLE the first read is issued straight from the request inputs.
    assign w_idle         = (r_state == ST_IDLE);
    assign w_cur_w        = w_idle ? roi_w     : r_w;
    assign w_cur_h        = w_idle ? roi_h     : r_h;
    assign w_cur_stride   = w_idle ? stride    : r_stride;
    assign w_cur_row_base = w_idle ? base_addr : r_row_base;
    assign w_cur_col      = w_idle ? '0        : r_col;
    assign w_cur_row      = w_idle ? '0        : r_row;

    assign w_zero      = (roi_w == '0) || (roi_h == '0);
    assign w_col_end   = (w_cur_col == w_cur_w - DIM_W'(1));
    assign w_row_end   = (w_cur_row == w_cur_h - DIM_W'(1));
    assign w_last_px   = w_col_end && w_row_end;
    assign w_credit    = {1'b0, w_fifo_count} + CRD_W'(r_p1_vld) + CRD_W'(r_p2_vld);
    assign w_credit_ok = (w_credit < CRD_W'(FIFO_DEPTH));
    assign w_pop       = m_axis.m_valid && m_axis.m_ready;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_zero) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_issue     = 1'b1;
                        w_state_nxt = w_last_px ? ST_DRAIN : ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (w_credit_ok) begin
                    w_issue = 1'b1;
                    if (w_last_px) w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_pop && w_head.last) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_w        <= '0;
            r_h        <= '0;
            r_stride   <= '0;
            r_row_base <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_raddr    <= '0;
            r_p1_vld   <= 1'b0;
            r_p2_vld   <= 1'b0;
            r_p1_flg   <= '0;
            r_p2_flg   <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done   <= w_done_nxt;
            r_p1_vld <= w_issue;
            r_p2_vld <= r_p1_vld;
            r_p2_flg <= r_p1_flg;
            if (w_idle && start) begin
                r_w      <= roi_w;
                r_h      <= roi_h;
                r_stride <= stride;
            end
            if (w_issue) begin
                r_raddr  <= w_cur_row_base + ADDR_W'(w_cur_col);
                r_p1_flg <= {(w_cur_col == '0), w_col_end, w_last_px};
                if (w_col_end) begin
                    r_col      <= '0;
                    r_row      <= w_cur_row + DIM_W'(1);
                    r_row_base <= w_cur_row_base + w_cur_stride;
                end else begin
                    r_col      <= w_cur_col + DIM_W'(1);
                    r_row      <= w_cur_row;
                    r_row_base <= w_cur_row_base;
                end
            end
        end
    end

    // Stage 2 lines up with the RAM's registered read data.
    assign w_fifo_din = '{data: mem_rdata, sol: r_p2_flg[2], eol: r_p2_flg[1], last: r_p2_flg[0]};

    stream_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (r_p2_vld),
        .din   (w_fifo_din),
        .pop   (w_pop),
        .dout  (w_head),
        .count (w_fifo_count),
        .empty (w_fifo_empty),
        .full  (w_fifo_full)
    );

    assign busy      = !w_idle;
    assign done      = r_done;
    assign mem_raddr = r_raddr;

    assign m_axis.m_valid = !w_fifo_empty;
    assign m_axis.m_data  = w_fifo_empty ? 8'h00 : w_head.data;
    assign m_axis.m_sol   = !w_fifo_empty && w_head.sol;
    assign m_axis.m_eol   = !w_fifo_empty && w_head.eol;
    assign m_axis.m_last  = !w_fifo_empty && w_head.last;

endmodule
